// File: rtl/dnn_argmax_fix.sv
// Argmax classifier stage: captures engine scores on a rising in_valid and scans
// them one class per cycle, reporting winning index, its score and the margin to
// the runner-up.
module dnn_argmax_fix #(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned N_CLASSES  = 10,
    parameter int unsigned IDX_WIDTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [N_CLASSES-1:0][DATA_WIDTH-1:0] scores,
    output logic                                 busy,
    output logic                                 valid,
    output logic [IDX_WIDTH-1:0]                 class_idx,
    output logic [DATA_WIDTH-1:0]                class_score,
    output logic [DATA_WIDTH:0]                  margin
);

    localparam logic [IDX_WIDTH-1:0]         LAST_IDX = IDX_WIDTH'(N_CLASSES - 1);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  score_q [N_CLASSES];
    logic signed [DATA_WIDTH-1:0]  best;
    logic signed [DATA_WIDTH-1:0]  second;
    logic [IDX_WIDTH-1:0]          best_idx;
    logic [IDX_WIDTH-1:0]          idx;
    logic                          in_valid_q;

    logic                          start_c;
    logic signed [DATA_WIDTH-1:0]  cur_c;
    logic signed [DATA_WIDTH-1:0]  nxt_best_c;
    logic signed [DATA_WIDTH-1:0]  nxt_second_c;
    logic [IDX_WIDTH-1:0]          nxt_best_idx_c;
    logic [DATA_WIDTH:0]           nxt_margin_c;

    assign start_c = in_valid & ~in_valid_q;

    // One compare step of the scan; strict > keeps the lowest index on ties
    always_comb begin
        cur_c          = score_q[idx];
        nxt_best_c     = best;
        nxt_second_c   = second;
        nxt_best_idx_c = best_idx;
        if (cur_c > best) begin
            nxt_second_c   = best;
            nxt_best_c     = cur_c;
            nxt_best_idx_c = idx;
        end else if (cur_c > second) begin
            nxt_second_c = cur_c;
        end
        nxt_margin_c = {nxt_best_c[DATA_WIDTH-1], nxt_best_c}
                     - {nxt_second_c[DATA_WIDTH-1], nxt_second_c};
    end

    // Scan FSM, score capture and registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            best        <= '0;
            second      <= '0;
            best_idx    <= '0;
            idx         <= '0;
            in_valid_q  <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            margin      <= '0;
            for (int i = 0; i < int'(N_CLASSES); i++) begin
                score_q[i] <= '0;
            end
        end else if (reset) begin
            state       <= ST_IDLE;
            best        <= '0;
            second      <= '0;
            best_idx    <= '0;
            idx         <= '0;
            in_valid_q  <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            margin      <= '0;
            for (int i = 0; i < int'(N_CLASSES); i++) begin
                score_q[i] <= '0;
            end
        end else begin
            in_valid_q <= in_valid;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_c) begin
                        for (int i = 0; i < int'(N_CLASSES); i++) begin
                            score_q[i] <= scores[i];
                        end
                        best     <= scores[0];
                        best_idx <= '0;
                        second   <= MOST_NEG;
                        idx      <= IDX_WIDTH'(1);
                        busy     <= 1'b1;
                        valid    <= 1'b0;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    best     <= nxt_best_c;
                    second   <= nxt_second_c;
                    best_idx <= nxt_best_idx_c;
                    if (idx == LAST_IDX) begin
                        busy        <= 1'b0;
                        valid       <= 1'b1;
                        class_idx   <= nxt_best_idx_c;
                        class_score <= nxt_best_c;
                        margin      <= nxt_margin_c;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_argmax_fix.sv
// Directed bench for dnn_argmax_fix.
module tb_dnn_argmax_fix;

    localparam int unsigned DW = 5;
    localparam int unsigned N  = 10;
    localparam int unsigned IW = 4;

    logic                  clk;
    logic                  rst;
    logic                  reset;
    logic                  in_valid;
    logic [N-1:0][DW-1:0]  scores;
    logic                  busy;
    logic                  valid;
    logic [IW-1:0]         class_idx;
    logic [DW-1:0]         class_score;
    logic [DW:0]           margin;

    int total;
    int passed;

    dnn_argmax_fix #(.DATA_WIDTH(DW), .N_CLASSES(N), .IDX_WIDTH(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .reset       (reset),
        .in_valid    (in_valid),
        .scores      (scores),
        .busy        (busy),
        .valid       (valid),
        .class_idx   (class_idx),
        .class_score (class_score),
        .margin      (margin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < int'(N); i++) scores[i] = DW'(v);
    endtask

    // Wait for valid after a capture sample; counts edges and busy samples
    task automatic measure(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!valid && lat < 20) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    // Raise in_valid with sc, capture, then scramble inputs and measure
    task automatic run_scan(input logic [N-1:0][DW-1:0] sc, input bit hold,
                            output logic cap_busy, output logic cap_valid,
                            output int lat, output int bcnt);
        scores   = sc;
        in_valid = 1'b1;
        step();
        cap_busy  = busy;
        cap_valid = valid;
        if (!hold) in_valid = 1'b0;
        fill(-1);
        measure(lat, bcnt);
    endtask

    task automatic test_reset();
        logic [N-1:0][DW-1:0] sc;
        int lat, bcnt;
        rst = 1'b0; reset = 1'b0; in_valid = 1'b0; fill(0);
        #12;
        total++;
        if ({busy, valid, class_idx, class_score, margin} !== '0)
            $display("FAIL reset_outputs: got %b expected 0", {busy, valid, class_idx, class_score, margin});
        else passed++;
        // in_valid already high at release must start exactly one scan
        for (int i = 0; i < int'(N); i++) sc[i] = DW'(i);
        sc[6] = DW'(14);
        scores = sc;
        in_valid = 1'b1;
        #4 rst = 1'b1;
        step();
        total++;
        if (busy !== 1'b1) $display("FAIL release_start_busy: got %b expected 1", busy);
        else passed++;
        fill(-1);
        measure(lat, bcnt);
        total++;
        if (lat !== 9 || class_idx !== IW'(6) || class_score !== DW'(14) || margin !== 6'd5)
            $display("FAIL release_scan: lat %0d idx %0d score %0d margin %0d expected 9/6/14/5",
                     lat, class_idx, $signed(class_score), margin);
        else passed++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [N-1:0][DW-1:0] sc;
        logic cb, cv;
        int lat, bcnt;
        sc[0] = DW'(1); sc[1] = DW'(0); sc[2] = DW'(3); sc[3] = DW'(2); sc[4] = DW'(1);
        sc[5] = DW'(0); sc[6] = DW'(2); sc[7] = DW'(15); sc[8] = DW'(1); sc[9] = DW'(0);
        run_scan(sc, 1'b0, cb, cv, lat, bcnt);
        total++;
        if (cb !== 1'b1 || cv !== 1'b0) $display("FAIL basic_capture: busy %b valid %b expected 1/0", cb, cv);
        else passed++;
        total++;
        if (lat !== 9) $display("FAIL basic_latency: got %0d expected 9", lat);
        else passed++;
        total++;
        if (bcnt !== 9 || busy !== 1'b0) $display("FAIL basic_busy_cycles: got %0d busy %b expected 9/0", bcnt, busy);
        else passed++;
        total++;
        if (class_idx !== IW'(7) || class_score !== DW'(15) || margin !== 6'd12)
            $display("FAIL basic_result: idx %0d score %0d margin %0d expected 7/15/12",
                     class_idx, $signed(class_score), margin);
        else passed++;
    endtask

    task automatic test_tie();
        logic [N-1:0][DW-1:0] sc;
        logic cb, cv;
        int lat, bcnt;
        for (int i = 0; i < int'(N); i++) sc[i] = DW'(-3);
        step();
        run_scan(sc, 1'b0, cb, cv, lat, bcnt);
        total++;
        if (lat !== 9 || class_idx !== IW'(0) || class_score !== DW'(-3) || margin !== 6'd0)
            $display("FAIL tie_result: lat %0d idx %0d score %0d margin %0d expected 9/0/-3/0",
                     lat, class_idx, $signed(class_score), margin);
        else passed++;
    endtask

    task automatic test_negative();
        logic [N-1:0][DW-1:0] sc;
        logic cb, cv;
        int lat, bcnt;
        for (int i = 0; i < int'(N); i++) sc[i] = DW'(-16);
        sc[9] = DW'(-1);
        sc[4] = DW'(-2);
        step();
        run_scan(sc, 1'b0, cb, cv, lat, bcnt);
        total++;
        if (class_idx !== IW'(9) || class_score !== DW'(-1) || margin !== 6'd1)
            $display("FAIL negative_result: idx %0d score %0d margin %0d expected 9/-1/1",
                     class_idx, $signed(class_score), margin);
        else passed++;
    endtask

    task automatic test_max_margin();
        logic [N-1:0][DW-1:0] sc;
        logic cb, cv;
        int lat, bcnt;
        for (int i = 0; i < int'(N); i++) sc[i] = DW'(-16);
        sc[3] = DW'(15);
        step();
        run_scan(sc, 1'b0, cb, cv, lat, bcnt);
        total++;
        if (class_idx !== IW'(3) || class_score !== DW'(15) || margin !== 6'd31)
            $display("FAIL max_margin: idx %0d score %0d margin %0d expected 3/15/31",
                     class_idx, $signed(class_score), margin);
        else passed++;
    endtask

    task automatic test_level_hold();
        logic [N-1:0][DW-1:0] sc;
        logic cb, cv;
        int lat, bcnt, extra_busy, valid_low;
        for (int i = 0; i < int'(N); i++) sc[i] = DW'(i - 5);
        step();
        run_scan(sc, 1'b1, cb, cv, lat, bcnt);
        extra_busy = 0;
        valid_low  = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (busy) extra_busy++;
            if (!valid) valid_low++;
        end
        total++;
        if (extra_busy !== 0 || valid_low !== 0 || class_idx !== IW'(9) || margin !== 6'd1)
            $display("FAIL hold_single_scan: extra busy %0d valid low %0d idx %0d margin %0d expected 0/0/9/1",
                     extra_busy, valid_low, class_idx, margin);
        else passed++;
        in_valid = 1'b0;
        step();
        for (int i = 0; i < int'(N); i++) sc[i] = DW'(2);
        sc[5] = DW'(10);
        run_scan(sc, 1'b0, cb, cv, lat, bcnt);
        total++;
        if (cv !== 1'b0 || cb !== 1'b1) $display("FAIL rerun_capture: valid %b busy %b expected 0/1", cv, cb);
        else passed++;
        total++;
        if (lat !== 9 || class_idx !== IW'(5) || class_score !== DW'(10) || margin !== 6'd8)
            $display("FAIL rerun_result: lat %0d idx %0d score %0d margin %0d expected 9/5/10/8",
                     lat, class_idx, $signed(class_score), margin);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0][DW-1:0] sc;
        int lat, bcnt;
        for (int i = 0; i < int'(N); i++) sc[i] = DW'(-16);
        sc[9] = DW'(-1);
        sc[4] = DW'(-2);
        step();
        scores = sc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        fill(7);
        step(); step(); step();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        measure(lat, bcnt);
        total++;
        if (lat !== 5 || class_idx !== IW'(9) || margin !== 6'd1)
            $display("FAIL midscan_start_ignored: lat %0d idx %0d margin %0d expected 5/9/1",
                     lat, class_idx, margin);
        else passed++;
        step(); step();
        total++;
        if (busy !== 1'b0 || valid !== 1'b1)
            $display("FAIL midscan_no_queue: busy %b valid %b expected 0/1", busy, valid);
        else passed++;
    endtask

    task automatic test_clear();
        logic [N-1:0][DW-1:0] sc;
        logic cb, cv;
        int lat, bcnt;
        for (int i = 0; i < int'(N); i++) sc[i] = DW'(1);
        sc[8] = DW'(9);
        step();
        scores = sc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step(); step();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({busy, valid, class_idx, class_score, margin} !== '0)
            $display("FAIL async_clear: got %b expected 0", {busy, valid, class_idx, class_score, margin});
        else passed++;
        #1 rst = 1'b1;
        step(); step(); step();
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL async_idle: busy %b valid %b expected 0/0", busy, valid);
        else passed++;
        scores = sc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step(); step();
        reset = 1'b1;
        #2;
        total++;
        if (busy !== 1'b1) $display("FAIL soft_not_async: busy %b expected 1", busy);
        else passed++;
        step();
        reset = 1'b0;
        total++;
        if ({busy, valid, class_idx, class_score, margin} !== '0)
            $display("FAIL soft_clear: got %b expected 0", {busy, valid, class_idx, class_score, margin});
        else passed++;
        step(); step();
        total++;
        if (busy !== 1'b0) $display("FAIL soft_idle: busy %b expected 0", busy);
        else passed++;
        run_scan(sc, 1'b0, cb, cv, lat, bcnt);
        total++;
        if (lat !== 9 || class_idx !== IW'(8) || class_score !== DW'(9) || margin !== 6'd8)
            $display("FAIL post_clear_result: lat %0d idx %0d score %0d margin %0d expected 9/8/9/8",
                     lat, class_idx, $signed(class_score), margin);
        else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_tie();
        test_negative();
        test_max_margin();
        test_level_hold();
        test_back_to_back();
        test_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
